// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl
//  Description : Pipeline hazard / stall / bubble controller for a five-stage
//                Y86-style pipeline. Detects load/use, RET-in-flight and
//                branch mispredict hazards, runs a RUN/DRAIN/HALTED status
//                FSM and keeps wrapping performance counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       D_icode,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       E_dstM,
    input  logic             e_cnd,
    input  logic [3:0]       M_icode,
    input  logic [1:0]       m_stat,
    input  logic [3:0]       W_icode,
    input  logic [1:0]       W_stat,
    output logic             F_stall,
    output logic             D_stall,
    output logic             D_bubble,
    output logic             E_bubble,
    output logic             M_bubble,
    output logic             W_stall,
    output logic             set_cc,
    output logic             halted,
    output logic [1:0]       proc_stat,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] ret_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    // Status and instruction encodings used by the hazard logic
    localparam logic [1:0] c_STAT_AOK  = 2'd0;
    localparam logic [3:0] c_I_NOP     = 4'h1;
    localparam logic [3:0] c_I_MRMOVQ  = 4'h5;
    localparam logic [3:0] c_I_OPQ     = 4'h6;
    localparam logic [3:0] c_I_JXX     = 4'h7;
    localparam logic [3:0] c_I_RET     = 4'h9;
    localparam logic [3:0] c_I_POPQ    = 4'hB;
    localparam logic [3:0] c_REG_NONE  = 4'hF;

    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Processor status FSM encoding
    localparam logic [1:0] c_ST_RUN    = 2'd0;
    localparam logic [1:0] c_ST_DRAIN  = 2'd1;
    localparam logic [1:0] c_ST_HALTED = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [1:0]       r_proc_stat;
    logic [CNT_W-1:0] r_cyc_cnt;
    logic [CNT_W-1:0] r_ret_cnt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_mispred_cnt;

    logic w_lu;
    logic w_rp;
    logic w_mp;
    logic w_is_halted;
    logic w_m_err;
    logic w_w_err;

    // Hazard detection: load/use needs a real destination register that a
    // decode-stage source reads; 0xF means "no register" and never matches.
    assign w_lu = ((E_icode == c_I_MRMOVQ) || (E_icode == c_I_POPQ)) &&
                  (E_dstM != c_REG_NONE) &&
                  ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    assign w_rp = (D_icode == c_I_RET) || (E_icode == c_I_RET) || (M_icode == c_I_RET);
    assign w_mp = (E_icode == c_I_JXX) && !e_cnd;

    assign w_is_halted = (r_state == c_ST_HALTED);
    assign w_m_err     = (m_stat != c_STAT_AOK);
    assign w_w_err     = (W_stat != c_STAT_AOK);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and pipeline control outputs; DRAIN shares RUN equations
    always_comb begin
        w_state_nxt = r_state;
        F_stall     = w_lu | w_rp;
        D_stall     = w_lu;
        D_bubble    = w_mp | (w_rp & ~w_lu);
        E_bubble    = w_mp | w_lu;
        M_bubble    = w_m_err | w_w_err;
        W_stall     = w_w_err;
        set_cc      = (E_icode == c_I_OPQ) && !w_m_err && !w_w_err;
        case (r_state)
            c_ST_RUN: begin
                // A writeback fault wins over a memory-stage fault
                if (w_w_err) begin
                    w_state_nxt = c_ST_HALTED;
                end else if (w_m_err) begin
                    w_state_nxt = c_ST_DRAIN;
                end
            end
            c_ST_DRAIN: begin
                if (w_w_err) begin
                    w_state_nxt = c_ST_HALTED;
                end
            end
            c_ST_HALTED: begin
                F_stall  = 1'b1;
                D_stall  = 1'b1;
                W_stall  = 1'b1;
                D_bubble = 1'b0;
                E_bubble = 1'b0;
                M_bubble = 1'b0;
                set_cc   = 1'b0;
            end
            default: begin
                w_state_nxt = c_ST_RUN;
            end
        endcase
    end

    // Final status: captured from writeback on the edge that enters HALTED
    always_ff @(posedge clk) begin
        if (reset) begin
            r_proc_stat <= c_STAT_AOK;
        end else if (!w_is_halted && w_w_err) begin
            r_proc_stat <= W_stat;
        end
    end

    // Performance counters, frozen while halted and wrapping silently
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cyc_cnt     <= '0;
            r_ret_cnt     <= '0;
            r_stall_cnt   <= '0;
            r_mispred_cnt <= '0;
        end else if (!w_is_halted) begin
            r_cyc_cnt <= r_cyc_cnt + c_CNT_ONE;
            if (!w_w_err && (W_icode != c_I_NOP)) begin
                r_ret_cnt <= r_ret_cnt + c_CNT_ONE;
            end
            if (w_lu) begin
                r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
            end
            if (w_mp) begin
                r_mispred_cnt <= r_mispred_cnt + c_CNT_ONE;
            end
        end
    end

    assign halted      = w_is_halted;
    assign proc_stat   = r_proc_stat;
    assign cyc_cnt     = r_cyc_cnt;
    assign ret_cnt     = r_ret_cnt;
    assign stall_cnt   = r_stall_cnt;
    assign mispred_cnt = r_mispred_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_ctrl
//  Description : Scoreboard bench for pipe_ctrl. A driver applies directed
//                and random cycles, predicts each cycle's outputs from a
//                behavioural model and queues them; a monitor on the falling
//                edge pops and compares.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;

    localparam int TB_CNT_W = 8;

    typedef struct packed {
        logic [3:0] d_icode;
        logic [3:0] srca;
        logic [3:0] srcb;
        logic [3:0] e_icode;
        logic [3:0] e_dstm;
        logic       e_cnd;
        logic [3:0] m_icode;
        logic [1:0] m_stat;
        logic [3:0] w_icode;
        logic [1:0] w_stat;
    } vec_t;

    typedef struct packed {
        logic                f_stall;
        logic                d_stall;
        logic                d_bubble;
        logic                e_bubble;
        logic                m_bubble;
        logic                w_stall;
        logic                set_cc;
        logic                halted;
        logic [1:0]          proc_stat;
        logic [TB_CNT_W-1:0] cyc;
        logic [TB_CNT_W-1:0] ret;
        logic [TB_CNT_W-1:0] stall;
        logic [TB_CNT_W-1:0] misp;
    } exp_t;

    logic clk;
    logic reset;
    logic [3:0] D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode, W_icode;
    logic       e_cnd;
    logic [1:0] m_stat, W_stat;
    logic F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc, halted;
    logic [1:0] proc_stat;
    logic [TB_CNT_W-1:0] cyc_cnt, ret_cnt, stall_cnt, mispred_cnt;

    pipe_ctrl #(.CNT_W(TB_CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .D_icode    (D_icode),
        .d_srcA     (d_srcA),
        .d_srcB     (d_srcB),
        .E_icode    (E_icode),
        .E_dstM     (E_dstM),
        .e_cnd      (e_cnd),
        .M_icode    (M_icode),
        .m_stat     (m_stat),
        .W_icode    (W_icode),
        .W_stat     (W_stat),
        .F_stall    (F_stall),
        .D_stall    (D_stall),
        .D_bubble   (D_bubble),
        .E_bubble   (E_bubble),
        .M_bubble   (M_bubble),
        .W_stall    (W_stall),
        .set_cc     (set_cc),
        .halted     (halted),
        .proc_stat  (proc_stat),
        .cyc_cnt    (cyc_cnt),
        .ret_cnt    (ret_cnt),
        .stall_cnt  (stall_cnt),
        .mispred_cnt(mispred_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model: processor either running or stopped; a pending
    // memory fault (drain) looks exactly like running from the outside.
    bit m_valid  = 1'b0;
    bit m_halted = 1'b0;
    int m_proc   = 0;
    int m_cyc    = 0;
    int m_ret    = 0;
    int m_stall  = 0;
    int m_misp   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_load_use(vec_t v);
        bit loads = (v.e_icode == 4'h5) || (v.e_icode == 4'hB);
        return loads && (v.e_dstm != 4'hF) && (v.e_dstm == v.srca || v.e_dstm == v.srcb);
    endfunction

    function automatic bit is_ret(vec_t v);
        return (v.d_icode == 4'h9) || (v.e_icode == 4'h9) || (v.m_icode == 4'h9);
    endfunction

    function automatic bit is_misp(vec_t v);
        return (v.e_icode == 4'h7) && (v.e_cnd == 1'b0);
    endfunction

    function automatic exp_t predict(vec_t v);
        exp_t e;
        bit lu = is_load_use(v);
        bit rp = is_ret(v);
        bit mp = is_misp(v);
        if (m_halted) begin
            e.f_stall = 1; e.d_stall = 1; e.w_stall = 1;
            e.d_bubble = 0; e.e_bubble = 0; e.m_bubble = 0; e.set_cc = 0;
        end else begin
            e.f_stall  = lu || rp;
            e.d_stall  = lu;
            e.d_bubble = mp || (rp && !lu);
            e.e_bubble = mp || lu;
            e.m_bubble = (v.m_stat != 0) || (v.w_stat != 0);
            e.w_stall  = (v.w_stat != 0);
            e.set_cc   = (v.e_icode == 4'h6) && (v.m_stat == 0) && (v.w_stat == 0);
        end
        e.halted    = m_halted;
        e.proc_stat = 2'(m_proc);
        e.cyc       = TB_CNT_W'(m_cyc % (1 << TB_CNT_W));
        e.ret       = TB_CNT_W'(m_ret % (1 << TB_CNT_W));
        e.stall     = TB_CNT_W'(m_stall % (1 << TB_CNT_W));
        e.misp      = TB_CNT_W'(m_misp % (1 << TB_CNT_W));
        return e;
    endfunction

    function automatic void advance(vec_t v);
        if (!m_halted) begin
            m_cyc++;
            if (v.w_stat == 0 && v.w_icode != 4'h1) m_ret++;
            if (is_load_use(v)) m_stall++;
            if (is_misp(v)) m_misp++;
            if (v.w_stat != 0) begin
                m_halted = 1'b1;
                m_proc   = int'(v.w_stat);
            end
        end
    endfunction

    function automatic vec_t idle();
        vec_t v;
        v.d_icode = 4'h1; v.srca = 4'hF; v.srcb = 4'hF;
        v.e_icode = 4'h1; v.e_dstm = 4'hF; v.e_cnd = 1'b1;
        v.m_icode = 4'h1; v.m_stat = 2'd0; v.w_icode = 4'h1; v.w_stat = 2'd0;
        return v;
    endfunction

    function automatic logic [3:0] rand_icode();
        logic [3:0] tbl [8] = '{4'h0, 4'h1, 4'h5, 4'h6, 4'h7, 4'h9, 4'hB, 4'h1};
        return tbl[$urandom_range(0, 7)];
    endfunction

    function automatic logic [3:0] rand_reg();
        return ($urandom_range(0, 4) == 0) ? 4'hF : 4'($urandom_range(0, 3));
    endfunction

    function automatic vec_t rand_vec(bit allow_faults);
        vec_t v;
        v.d_icode = rand_icode(); v.srca = rand_reg(); v.srcb = rand_reg();
        v.e_icode = rand_icode(); v.e_dstm = rand_reg(); v.e_cnd = 1'($urandom_range(0, 1));
        v.m_icode = rand_icode(); v.w_icode = rand_icode();
        v.m_stat  = (allow_faults && $urandom_range(0, 29) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
        v.w_stat  = (allow_faults && $urandom_range(0, 59) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
        return v;
    endfunction

    // One clock cycle: drive, predict, let the edge happen, update model
    task automatic cycle(input bit rst_v, input vec_t v);
        reset   = rst_v;
        D_icode = v.d_icode; d_srcA = v.srca; d_srcB = v.srcb;
        E_icode = v.e_icode; E_dstM = v.e_dstm; e_cnd = v.e_cnd;
        M_icode = v.m_icode; m_stat = v.m_stat; W_icode = v.w_icode; W_stat = v.w_stat;
        if (m_valid) q.push_back(predict(v));
        @(posedge clk);
        if (rst_v) begin
            m_valid = 1'b1; m_halted = 1'b0; m_proc = 0;
            m_cyc = 0; m_ret = 0; m_stall = 0; m_misp = 0;
        end else if (m_valid) begin
            advance(v);
        end
        #1;
    endtask

    // Monitor: outputs are combinational, so every driven cycle is compared
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("F_stall",     32'(F_stall),     32'(e.f_stall));
            chk("D_stall",     32'(D_stall),     32'(e.d_stall));
            chk("D_bubble",    32'(D_bubble),    32'(e.d_bubble));
            chk("E_bubble",    32'(E_bubble),    32'(e.e_bubble));
            chk("M_bubble",    32'(M_bubble),    32'(e.m_bubble));
            chk("W_stall",     32'(W_stall),     32'(e.w_stall));
            chk("set_cc",      32'(set_cc),      32'(e.set_cc));
            chk("halted",      32'(halted),      32'(e.halted));
            chk("proc_stat",   32'(proc_stat),   32'(e.proc_stat));
            chk("cyc_cnt",     32'(cyc_cnt),     32'(e.cyc));
            chk("ret_cnt",     32'(ret_cnt),     32'(e.ret));
            chk("stall_cnt",   32'(stall_cnt),   32'(e.stall));
            chk("mispred_cnt", 32'(mispred_cnt), 32'(e.misp));
        end
    end

    initial begin
        vec_t v;
        int   waited;
        cycle(1'b1, idle());
        cycle(1'b0, idle());

        // Load/use on srcA
        v = idle(); v.e_icode = 4'h5; v.e_dstm = 4'h3; v.srca = 4'h3;
        cycle(1'b0, v);
        // Load/use through srcB with POPQ
        v = idle(); v.e_icode = 4'hB; v.e_dstm = 4'h2; v.srcb = 4'h2;
        cycle(1'b0, v);
        // Mispredicted branch, then a taken branch
        v = idle(); v.e_icode = 4'h7; v.e_cnd = 1'b0;
        cycle(1'b0, v);
        v.e_cnd = 1'b1;
        cycle(1'b0, v);
        // RET in decode for three cycles, then RET alongside load/use
        v = idle(); v.d_icode = 4'h9;
        repeat (3) cycle(1'b0, v);
        v.e_icode = 4'h5; v.e_dstm = 4'h4; v.srca = 4'h4;
        cycle(1'b0, v);
        // No register on either side must not look like a hazard
        v = idle(); v.e_icode = 4'h5; v.e_dstm = 4'hF; v.srca = 4'hF;
        cycle(1'b0, v);
        // OPQ with clean status writes condition codes; with a fault it must not
        v = idle(); v.e_icode = 4'h6; v.w_icode = 4'h6;
        cycle(1'b0, v);
        v.m_stat = 2'd2;
        cycle(1'b0, v);
        // Now draining: reset mid-drain
        cycle(1'b1, idle());
        cycle(1'b0, idle());
        // Memory fault, then writeback fault, then sit halted
        v = idle(); v.m_stat = 2'd1;
        cycle(1'b0, v);
        v = idle(); v.w_stat = 2'd1; v.w_icode = 4'h0;
        cycle(1'b0, v);
        v = idle(); v.e_icode = 4'h6; v.e_dstm = 4'h1; v.w_icode = 4'h6;
        repeat (3) cycle(1'b0, v);
        // Reset while halted, then run clean
        cycle(1'b1, idle());
        cycle(1'b0, idle());
        // Writeback fault takes priority over memory fault in the same cycle
        v = idle(); v.m_stat = 2'd3; v.w_stat = 2'd2;
        cycle(1'b0, v);
        cycle(1'b0, idle());
        cycle(1'b1, idle());

        // Long fault-free run so the narrow counters wrap
        repeat (600) cycle(1'b0, rand_vec(1'b0));

        // Random run with occasional faults and resets
        for (int i = 0; i < 4000; i++) begin
            bit r = m_halted ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 299) == 0);
            cycle(r, rand_vec(1'b1));
        end

        waited = 0;
        while (q.size() > 0 && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        chk("scoreboard_drained", 32'(q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
